serial_demux8: RTL

Serial-to-parallel 1:8 demultiplexer. It takes a framed serial bit stream and steers each bit into the lane selected by an internal 3-bit slot counter, using the same select encoding as the team's 8:1 select-line mux, so it is the receiving end of a mux-driven serializer. Completed frames are presented as an 8-bit word through a valid/ready output buffer. Partial-frame resynchronisation and overrun detection are built in.

---
 rtl/serial_demux8_pkg.sv | 12 +
 rtl/serial_demux8_out_buf.sv | 55 +++++
 rtl/serial_demux8.sv | 85 ++++++++
 3 files changed

// File: rtl/serial_demux8_pkg.sv
// rtl/serial_demux8_pkg.sv - shared widths and FSM state type for serial_demux8
package serial_demux8_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int N_LANES   = 1 << SEL_W_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_demux8_out_buf.sv
// rtl/serial_demux8_out_buf.sv - one-entry valid/ready word buffer with sticky overrun
module demux_out_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         out_ready,
  input  logic         clear_ovr,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         overrun
);

  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  logic         drain, accept;

  // A drain on the same edge frees the slot, so a completing word may load.
  assign drain  = valid_q && out_ready;
  assign accept = load && (!valid_q || drain);

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept) begin
      dout_d  = word;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    if (clear_ovr) ovr_d = 1'b0;
    if (load && !accept) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/serial_demux8.sv
// rtl/serial_demux8.sv - framed serial-to-parallel 1:N demultiplexer top level
module serial_demux8
  import serial_demux8_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    start,
  input  logic                    out_ready,
  input  logic                    clear_ovr,
  output logic [(1<<SEL_W)-1:0]   dout,
  output logic                    dout_valid,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    overrun
);

  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     asm_q, asm_d;
  logic             frame_done;

  // start always wins, so a start at the last slot resyncs instead of completing.
  assign frame_done = din_valid && !start && (state_q == SHIFT) && (sel_q == SEL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (din_valid && start) state_d = SHIFT;
    else if (frame_done)    state_d = IDLE;
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  always_comb begin
    sel_d = sel_q;
    asm_d = asm_q;
    if (din_valid && start) begin
      asm_d[0] = din;
      sel_d    = SEL_ONE;
    end else if (din_valid && (state_q == SHIFT)) begin
      asm_d[sel_q] = din;
      sel_d        = sel_q + SEL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      asm_q <= '0;
    end else begin
      sel_q <= sel_d;
      asm_q <= asm_d;
    end
  end

  assign sel = sel_q;

  // asm_d already holds the final bit, giving zero-cycle completion latency.
  demux_out_buf #(.W(N)) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (frame_done),
    .word       (asm_d),
    .out_ready  (out_ready),
    .clear_ovr  (clear_ovr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule
